// File: rtl/diff_channel_scheduler_if.sv
// Handshake bundle for diff_channel_scheduler: per-channel sample inputs on one side,
// registered difference stream on the other.
// The sat_flag signal only exists when DIFF_SAT_EN is defined.
interface diff_channel_scheduler_if #(
   parameter int unsigned N  = 4,
   parameter int unsigned W  = 8,
   parameter int unsigned CW = 2
);
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           clear;
   logic           out_valid;
   logic           out_ready;
   logic [W:0]     out_diff;
   logic [CW-1:0]  out_chan;
   logic [N-1:0]   primed;
`ifdef DIFF_SAT_EN
   logic           sat_flag;
`endif

   // Source / sink side (sample producers and downstream consumer)
   modport master (
      output in_valid, in_data, clear, out_ready,
      input  in_ready, out_valid, out_diff, out_chan, primed
`ifdef DIFF_SAT_EN
      , input sat_flag
`endif
   );

   // Scheduler side
   modport slave (
      input  in_valid, in_data, clear, out_ready,
      output in_ready, out_valid, out_diff, out_chan, primed
`ifdef DIFF_SAT_EN
      , output sat_flag
`endif
   );
endinterface

// File: rtl/diff_channel_scheduler.sv
// Round-robin time-shared first-difference unit: y[n] = x[n] - x[n-1] per channel.
// One channel is granted per cycle; its previous sample lives in a per-channel bank.
// A single registered output word carries the difference and the channel tag.
// Optional: define DIFF_SAT_EN to clamp the result to the signed W-bit range and add sat_flag.
module diff_channel_scheduler #(
   parameter int unsigned N  = 4,
   parameter int unsigned W  = 8,
   parameter int unsigned CW = 2
) (
   input logic                     clk,
   input logic                     rst,
   diff_channel_scheduler_if.slave bus
);

   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  ptr_q, ptr_d;
   logic [N-1:0]   primed_q, primed_d;
   logic [W-1:0]   prev_q [N];
   logic [W-1:0]   prev_d [N];
   logic [W:0]     diff_q, diff_d;
   logic [CW-1:0]  chan_q, chan_d;
   logic           sat_q, sat_d;

   logic           free;
   logic           grant_vld;
   logic [CW-1:0]  grant;
   logic [N-1:0]   rdy;
   logic           accept;
   logic           primed_acc;
   logic [W-1:0]   sel_data;
   logic [W-1:0]   sel_prev;
   logic [W:0]     diff_full;
   logic [W:0]     diff_res;
   logic           sat_hit;

   assign free = (state_q == StEmpty) || bus.out_ready;

   // Round-robin search starting at the pointer, wrapping N-1 -> 0
   always_comb begin
      logic [CW-1:0] cand;
      grant_vld = 1'b0;
      grant     = '0;
      cand      = '0;
      for (int i = 0; i < int'(N); i++) begin
         cand = CW'((int'(ptr_q) + i) % int'(N));
         if (!grant_vld && bus.in_valid[cand]) begin
            grant_vld = 1'b1;
            grant     = cand;
         end
      end
   end

   // Grant is one-hot; suppressed under backpressure and while in reset
   always_comb begin
      rdy = '0;
      if (!rst && free && grant_vld) begin
         rdy[grant] = 1'b1;
      end
   end

   assign accept     = |rdy;
   assign primed_acc = accept && primed_q[grant];
   assign sel_data   = bus.in_data[int'(grant)*int'(W) +: W];
   assign sel_prev   = prev_q[grant];

   // Difference at W+1 bits is always exact; optional clamp to signed W-bit range
   always_comb begin
      diff_full = {sel_data[W-1], sel_data} - {sel_prev[W-1], sel_prev};
      diff_res  = diff_full;
      sat_hit   = 1'b0;
`ifdef DIFF_SAT_EN
      if (diff_full[W] != diff_full[W-1]) begin
         sat_hit  = 1'b1;
         diff_res = diff_full[W] ? {2'b11, {(W-1){1'b0}}} : {2'b00, {(W-1){1'b1}}};
      end
`endif
   end

   // Next-state: output FSM, output word, history bank and pointer
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      diff_d   = diff_q;
      chan_d   = chan_q;
      sat_d    = sat_q;
      prev_d   = prev_q;
      primed_d = bus.clear ? '0 : primed_q;

      unique case (state_q)
         StEmpty: if (primed_acc) state_d = StFull;
         StFull: begin
            if (primed_acc) begin
               state_d = StFull;
            end else if (bus.out_ready) begin
               state_d = StEmpty;
            end
         end
         default: state_d = StEmpty;
      endcase

      if (accept) begin
         prev_d[grant]   = sel_data;
         primed_d[grant] = 1'b1;
         ptr_d = (grant == CW'(N - 1)) ? '0 : grant + CW'(1);
      end

      // New word replaces the old one, so draining and refilling costs no bubble
      if (primed_acc) begin
         diff_d = diff_res;
         chan_d = grant;
         sat_d  = sat_hit;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StEmpty;
         ptr_q    <= '0;
         primed_q <= '0;
         diff_q   <= '0;
         chan_q   <= '0;
         sat_q    <= 1'b0;
         for (int k = 0; k < int'(N); k++) begin
            prev_q[k] <= '0;
         end
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         primed_q <= primed_d;
         diff_q   <= diff_d;
         chan_q   <= chan_d;
         sat_q    <= sat_d;
         prev_q   <= prev_d;
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = (state_q == StFull);
   assign bus.out_diff  = diff_q;
   assign bus.out_chan  = chan_q;
   assign bus.primed    = primed_q;
`ifdef DIFF_SAT_EN
   assign bus.sat_flag  = sat_q;
`endif

   // Simulation checks: grant shape and output stability under stall
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert ($onehot0(bus.in_ready))
            else $error("in_ready not one-hot or zero");
      end
   end

   assert property (@(posedge clk) disable iff (rst)
      (bus.out_valid && !bus.out_ready) |=> ($stable(bus.out_diff) && $stable(bus.out_chan)))
      else $error("output word changed while stalled");

endmodule

// File: doc/diff_channel_scheduler.md
Name: diff_channel_scheduler

Overview:
- Time-shares one signed first-difference datapath, y[n] = x[n] - x[n-1], between N independent sample channels.
- Round-robin arbitration picks one channel per cycle. A per-channel previous-sample bank holds each channel's x[n-1].
- One registered output stage carries the difference and a channel tag downstream.
- Sits between the front-end sample sources and the feature-extraction stage.

Parameters:
- N, 4, number of requesting channels (2..16).
- W, 8, sample width, two's complement.
- CW, 2, channel-ID width, must equal clog2(N).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel sample valid.
- in_data  input  N*W  channel k sample in bits [k*W +: W].
- in_ready  output  N  per-channel accept, one-hot or zero.
- clear  input  1  forget history: clears all primed flags.
- out_valid  output  1  difference valid.
- out_ready  input  1  downstream accept.
- out_diff  output  W+1  signed difference.
- out_chan  output  CW  channel that produced out_diff.
- primed  output  N  per-channel "history held" status.

Behaviour:
- Reset (rst=1 at edge):
  - out_valid=0, out_diff=0, out_chan=0.
  - primed=0, previous-sample bank=0, round-robin pointer=0.
  - in_ready is forced to 0 while rst=1.
- Stage free:
  - free = !out_valid || out_ready.
  - in_ready is 0 on every bit when free=0 (backpressure).
- Arbitration:
  - When free=1, grant the first channel with in_valid=1, searching from the pointer upward with wrap from N-1 to 0.
  - in_ready[g]=1 for the granted channel only. This is combinational from in_valid, the pointer and free.
  - No grant when no channel is valid; the pointer holds.
- Accept:
  - Accept occurs when in_valid[g] && in_ready[g].
  - On accept, the pointer becomes (g+1) mod N.
- Accept on a primed channel:
  - Next edge: out_diff = sext(in_data_g) - sext(prev[g]), computed at W+1 bits (always exact).
  - Next edge: out_chan=g, out_valid=1.
  - prev[g] <= in_data_g.
  - Latency: 1 cycle.
- Accept on an unprimed channel:
  - prev[g] <= in_data_g, primed[g] <= 1.
  - No output is produced. out_valid falls if out_ready consumed the current word.
- Output hold: while out_valid=1 && out_ready=0, out_diff and out_chan are held stable.
- Output drain: out_ready=1 with no new primed accept clears out_valid at the next edge.
- Simultaneous output drain and primed accept: the new word replaces the old one; no bubble.
- Clear:
  - clear=1 sets primed to 0 at the next edge. The previous-sample bank is left as is.
  - If an accept occurs in the same cycle, clear wins for every other channel. The accepted channel ends primed with prev set to the new sample.
  - Within that rule, an accept on a channel that was primed still emits its difference.
  - The pending output word is not affected.
- Reset mid-operation: any pending word is dropped and all history is lost. In-flight handshakes are not completed.
- Internal FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on a primed accept.
  - FULL -> EMPTY on out_ready with no primed accept.
  - FULL -> FULL when the output word is held or replaced.
- Assertions (simulation only):
  - in_ready is one-hot or zero.
  - out_diff is stable while stalled.

Optional Feature:
- Macro: DIFF_SAT_EN.
- Defined:
  - out_diff is clamped to the signed W-bit range [-2^(W-1), 2^(W-1)-1], then sign-extended to W+1 bits.
  - An extra output port sat_flag (1 bit, registered) is added. It is 1 when clamping occurred for the current word and resets to 0.
- Not defined: full-precision W+1-bit result, and no sat_flag port.

Test Plan (N=4, W=8):
- Channel 0 sends 10 then 25 -> first accept produces no output and primed[0]=1. Second accept gives out_valid=1 one cycle later with out_diff=15 (0x00F) and out_chan=0.
- Channel 1 sends 127 then -128 (0x80):
  - Without DIFF_SAT_EN -> out_diff=-255 (0x101).
  - With DIFF_SAT_EN -> out_diff=-128 (0x180) and sat_flag=1.
- All four channels primed, in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0,1, one word per cycle, no bubbles.
- Word pending on channel 2, out_ready=0 for 3 cycles with in_valid=4'b1111 -> in_ready=0 throughout and out_diff/out_chan stable. After release, the next grant is channel 3.
- All channels primed, clear=1 for one cycle -> primed=0. Each channel's next sample produces no output; the following sample produces the correct difference.
- rst=1 for one cycle while out_valid=1 -> next edge gives out_valid=0, out_diff=0, primed=0, pointer at 0. The first post-reset grant with in_valid=4'b1010 is channel 1.
